// File: rtl/movavg_pkg.sv
// Shared sizing helpers and legal parameter range for the streaming moving-average filter.
// Pure elaboration-time content: no logic, no latency, no flow control.
package movavg_pkg;

   localparam int DEPTH_LOG2_MIN = 1;
   localparam int DEPTH_LOG2_MAX = 6;

   function automatic int sum_width(input int width, input int depth_log2);
      return width + depth_log2;
   endfunction

   function automatic bit depth_log2_legal(input int depth_log2);
      return (depth_log2 >= DEPTH_LOG2_MIN) && (depth_log2 <= DEPTH_LOG2_MAX);
   endfunction

endpackage

// File: rtl/movavg_window.sv
// Circular sample buffer: presents the oldest entry (the one about to be overwritten) and the fill count.
// Write takes effect at the next edge; clear flushes the window; no backpressure.
module movavg_window #(
   parameter int WIDTH      = 64,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  clear,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      oldest,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
         wptr_d  = '0;
         count_d = '0;
      end else if (push) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + 1'b1;
         if (count_q != FULL_CNT) count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Unwritten entries are zero, so the subtracted term is 0 until the window wraps.
   assign oldest = mem_q[wptr_q];
   assign count  = count_q;

endmodule

// File: rtl/movavg_stream.sv
// Streaming moving average over 2**DEPTH_LOG2 samples: running sum plus registered sum/mean outputs.
// One cycle from accepted sample to dout_valid; accepts a sample every cycle, no backpressure.
module movavg_stream
   import movavg_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int DEPTH_LOG2 = 2,
   parameter bit NORMALIZE  = 1'b1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     in_valid,
   input  logic [WIDTH-1:0]                         din,
   input  logic                                     clear,
   output logic                                     dout_valid,
   output logic [WIDTH-1:0]                         dout,
   output logic [sum_width(WIDTH, DEPTH_LOG2)-1:0]  dsum,
   output logic                                     dout_full
);

   localparam int SW = sum_width(WIDTH, DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0] LAST_CNT = {1'b0, {DEPTH_LOG2{1'b1}}};

   generate
      if (!depth_log2_legal(DEPTH_LOG2)) begin : g_bad_depth
         $error("movavg_stream: DEPTH_LOG2 outside supported range");
      end
   endgenerate

   logic [WIDTH-1:0]    oldest;
   logic [DEPTH_LOG2:0] fill_cnt;
   logic [SW-1:0]       sum_acc;

   logic [SW-1:0]    sum_q, sum_d;
   logic [SW-1:0]    dsum_q, dsum_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             dout_full_q, dout_full_d;

   movavg_window #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_window (
      .clk    (clk),
      .rst    (reset),
      .push   (in_valid),
      .clear  (clear),
      .din    (din),
      .oldest (oldest),
      .count  (fill_cnt)
   );

   // The sum always covers the oldest entry, so the subtraction cannot underflow.
   assign sum_acc = sum_q + {{DEPTH_LOG2{1'b0}}, din} - {{DEPTH_LOG2{1'b0}}, oldest};

   always_comb begin
      sum_d        = sum_q;
      dsum_d       = dsum_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      dout_full_d  = dout_full_q;
      if (clear) begin
         sum_d       = '0;
         dout_full_d = 1'b0;
      end else if (in_valid) begin
         sum_d        = sum_acc;
         dsum_d       = sum_acc;
         dout_d       = NORMALIZE ? sum_acc[SW-1:DEPTH_LOG2] : sum_acc[WIDTH-1:0];
         dout_valid_d = 1'b1;
         dout_full_d  = (fill_cnt >= LAST_CNT);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q        <= '0;
         dsum_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_full_q  <= 1'b0;
      end else begin
         sum_q        <= sum_d;
         dsum_q       <= dsum_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_full_q  <= dout_full_d;
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout       = dout_q;
   assign dsum       = dsum_q;
   assign dout_full  = dout_full_q;

endmodule

// File: tb/tb_movavg_stream.sv
// Bench for movavg_stream: three configurations share one stimulus stream, checked against a sample-history model.
module tb_movavg_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] din;
   logic        clear;

   logic        vld_a, vld_b, vld_c;
   logic [63:0] dout_a, dout_b, dout_c;
   logic [65:0] dsum_a, dsum_b;
   logic [66:0] dsum_c;
   logic        full_a, full_b, full_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   movavg_stream #(.WIDTH(64), .DEPTH_LOG2(2), .NORMALIZE(1'b1)) u_a (
      .clk(clk), .reset(rst), .in_valid(in_valid), .din(din), .clear(clear),
      .dout_valid(vld_a), .dout(dout_a), .dsum(dsum_a), .dout_full(full_a));
   movavg_stream #(.WIDTH(64), .DEPTH_LOG2(2), .NORMALIZE(1'b0)) u_b (
      .clk(clk), .reset(rst), .in_valid(in_valid), .din(din), .clear(clear),
      .dout_valid(vld_b), .dout(dout_b), .dsum(dsum_b), .dout_full(full_b));
   movavg_stream #(.WIDTH(64), .DEPTH_LOG2(3), .NORMALIZE(1'b1)) u_c (
      .clk(clk), .reset(rst), .in_valid(in_valid), .din(din), .clear(clear),
      .dout_valid(vld_c), .dout(dout_c), .dsum(dsum_c), .dout_full(full_c));

   logic        got_vld [3];
   logic [63:0] got_dout[3];
   logic [69:0] got_dsum[3];
   logic        got_full[3];

   assign got_vld[0] = vld_a;  assign got_dout[0] = dout_a;
   assign got_vld[1] = vld_b;  assign got_dout[1] = dout_b;
   assign got_vld[2] = vld_c;  assign got_dout[2] = dout_c;
   assign got_dsum[0] = {4'd0, dsum_a};
   assign got_dsum[1] = {4'd0, dsum_b};
   assign got_dsum[2] = {3'd0, dsum_c};
   assign got_full[0] = full_a;
   assign got_full[1] = full_b;
   assign got_full[2] = full_c;

   // Reference model: history of accepted samples; each window is summed from it directly.
   int          cfg_dl  [3] = '{2, 2, 3};
   bit          cfg_norm[3] = '{1'b1, 1'b0, 1'b1};
   logic [63:0] hist[$];
   logic        exp_vld;
   logic [63:0] exp_dout[3];
   logic [69:0] exp_dsum[3];
   logic        exp_full[3];

   function automatic logic [69:0] win_sum(input int k);
      logic [69:0] s = '0;
      int n = hist.size();
      int d = 1 << cfg_dl[k];
      for (int i = (n > d) ? n - d : 0; i < n; i++) s += {6'd0, hist[i]};
      return s;
   endfunction

   task automatic model_reset();
      hist.delete();
      exp_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_dout[k] = '0;
         exp_dsum[k] = '0;
         exp_full[k] = 1'b0;
      end
   endtask

   task automatic drive(input bit v, input logic [63:0] d, input bit c);
      logic [69:0] s, t;
      in_valid = v;
      din      = d;
      clear    = c;
      @(posedge clk);
      if (c) begin
         hist.delete();
         exp_vld = 1'b0;
         for (int k = 0; k < 3; k++) exp_full[k] = 1'b0;
      end else if (v) begin
         hist.push_back(d);
         if (hist.size() > 64) void'(hist.pop_front());
         exp_vld = 1'b1;
         for (int k = 0; k < 3; k++) begin
            s = win_sum(k);
            t = s >> cfg_dl[k];
            exp_dsum[k] = s;
            exp_dout[k] = cfg_norm[k] ? t[63:0] : s[63:0];
            exp_full[k] = (hist.size() >= (1 << cfg_dl[k]));
         end
      end else begin
         exp_vld = 1'b0;
      end
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got_vld[k] !== 1'b0 || got_dout[k] !== 64'd0 || got_dsum[k] !== 70'd0 || got_full[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset k=%0d got vld=%b dout=%h dsum=%h full=%b want all 0",
                     k, got_vld[k], got_dout[k], got_dsum[k], got_full[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill();
      logic [69:0] ed[4] = '{70'd4, 70'd12, 70'd24, 70'd40};
      logic [63:0] eo[4] = '{64'd1, 64'd3, 64'd6, 64'd10};
      logic        ef[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'(4 * (i + 1)), 1'b0);
         checks++;
         if (got_vld[0] !== 1'b1 || got_dsum[0] !== ed[i] || got_dout[0] !== eo[i] || got_full[0] !== ef[i]) begin
            errors++;
            $display("FAIL fill[%0d] got vld=%b dsum=%0d dout=%0d full=%b want 1 %0d %0d %b",
                     i, got_vld[0], got_dsum[0], got_dout[0], got_full[0], ed[i], eo[i], ef[i]);
         end
         checks++;
         if (got_dout[1] !== exp_dout[1]) begin
            errors++;
            $display("FAIL fill_raw[%0d] got %0d want %0d", i, got_dout[1], exp_dout[1]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [69:0] ed[4] = '{70'd48, 70'd36, 70'd20, 70'd0};
      drive(1'b1, 64'd20, 1'b0);
      checks++;
      if (got_dsum[0] !== 70'd56 || got_dout[0] !== 64'd14 || got_full[0] !== 1'b1) begin
         errors++;
         $display("FAIL wrap20 got dsum=%0d dout=%0d full=%b want 56 14 1", got_dsum[0], got_dout[0], got_full[0]);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'd0, 1'b0);
         checks++;
         if (got_dsum[0] !== ed[i] || got_dsum[2] !== exp_dsum[2]) begin
            errors++;
            $display("FAIL wrap0[%0d] got %0d/%0d want %0d/%0d", i, got_dsum[0], got_dsum[2], ed[i], exp_dsum[2]);
         end
      end
   endtask

   task automatic test_gap();
      bit          ev[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [69:0] ed[4] = '{70'd5, 70'd5, 70'd5, 70'd14};
      logic [63:0] sd[4] = '{64'd5, 64'd0, 64'd0, 64'd9};
      drive(1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(ev[i], sd[i], 1'b0);
         checks++;
         if (got_vld[0] !== ev[i] || got_dsum[0] !== ed[i]) begin
            errors++;
            $display("FAIL gap[%0d] got vld=%b dsum=%0d want %b %0d", i, got_vld[0], got_dsum[0], ev[i], ed[i]);
         end
      end
   endtask

   task automatic test_saturate();
      drive(1'b0, 64'd0, 1'b1);
      repeat (4) drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      checks++;
      if (got_dsum[0] !== 70'h3_FFFF_FFFF_FFFF_FFFC || got_dout[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL sat_mean got dsum=%h dout=%h", got_dsum[0], got_dout[0]);
      end
      checks++;
      if (got_dout[1] !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         errors++;
         $display("FAIL sat_raw got %h want fffffffffffffffc", got_dout[1]);
      end
   endtask

   task automatic test_clear();
      drive(1'b0, 64'd0, 1'b1);
      drive(1'b1, 64'd1, 1'b0);
      drive(1'b1, 64'd2, 1'b0);
      drive(1'b1, 64'd3, 1'b0);
      drive(1'b1, 64'd100, 1'b1);
      checks++;
      if (got_vld[0] !== 1'b0 || got_full[0] !== 1'b0 || got_dsum[0] !== 70'd6) begin
         errors++;
         $display("FAIL clear_win got vld=%b full=%b dsum=%0d want 0 0 6", got_vld[0], got_full[0], got_dsum[0]);
      end
      drive(1'b1, 64'd7, 1'b0);
      checks++;
      if (got_vld[0] !== 1'b1 || got_dsum[0] !== 70'd7) begin
         errors++;
         $display("FAIL clear_next got vld=%b dsum=%0d want 1 7", got_vld[0], got_dsum[0]);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 64'd11, 1'b0);
      drive(1'b1, 64'd22, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got_vld[k] !== 1'b0 || got_dout[k] !== 64'd0 || got_dsum[k] !== 70'd0 || got_full[k] !== 1'b0) begin
            errors++;
            $display("FAIL async_rst k=%0d got vld=%b dout=%h dsum=%h full=%b want all 0",
                     k, got_vld[k], got_dout[k], got_dsum[k], got_full[k]);
         end
      end
      #1;
      rst = 1'b0;
      model_reset();
      repeat (8) drive(1'b1, 64'd8, 1'b0);
      checks++;
      if (got_dsum[2] !== 70'd64 || got_dout[2] !== 64'd8 || got_full[2] !== 1'b1) begin
         errors++;
         $display("FAIL depth8 got dsum=%0d dout=%0d full=%b want 64 8 1", got_dsum[2], got_dout[2], got_full[2]);
      end
      drive(1'b1, 64'd0, 1'b0);
      checks++;
      if (got_dsum[2] !== 70'd56 || got_dout[2] !== 64'd7) begin
         errors++;
         $display("FAIL depth8_wrap got dsum=%0d dout=%0d want 56 7", got_dsum[2], got_dout[2]);
      end
   endtask

   task automatic test_random();
      bit          v, c;
      logic [63:0] d;
      for (int n = 0; n < 400; n++) begin
         v = ($urandom_range(0, 9) < 7);
         c = ($urandom_range(0, 24) == 0);
         d = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         drive(v, d, c);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_vld[k] !== exp_vld || got_dsum[k] !== exp_dsum[k] ||
                got_dout[k] !== exp_dout[k] || got_full[k] !== exp_full[k]) begin
               errors++;
               $display("FAIL rand[%0d] k=%0d got %b %h %h %b want %b %h %h %b", n, k,
                        got_vld[k], got_dsum[k], got_dout[k], got_full[k],
                        exp_vld, exp_dsum[k], exp_dout[k], exp_full[k]);
            end
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      din      = '0;
      clear    = 1'b0;
      model_reset();
      test_reset();
      test_fill();
      test_wrap();
      test_gap();
      test_saturate();
      test_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
